// File: rtl/muldiv_seq_pkg.sv
// Shared constants for the RV32M multiply/divide sequencer and its
// control-unit hookup: opcode fields, FSM encodings and write-back select.
package muldiv_seq_pkg;

    // func7 value that marks an OP instruction as an RV32M operation.
    localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

    // func3 operation select.
    localparam logic [2:0] FUNC3_MUL    = 3'b000;
    localparam logic [2:0] FUNC3_MULH   = 3'b001;
    localparam logic [2:0] FUNC3_MULHSU = 3'b010;
    localparam logic [2:0] FUNC3_MULHU  = 3'b011;
    localparam logic [2:0] FUNC3_DIV    = 3'b100;
    localparam logic [2:0] FUNC3_DIVU   = 3'b101;
    localparam logic [2:0] FUNC3_REM    = 3'b110;
    localparam logic [2:0] FUNC3_REMU   = 3'b111;

    // Sequencer FSM encodings.
    localparam logic [1:0] MD_IDLE = 2'd0;
    localparam logic [1:0] MD_CALC = 2'd1;
    localparam logic [1:0] MD_FIX  = 2'd2;
    localparam logic [1:0] MD_DONE = 2'd3;

    // Cycles from the accepted start to the done pulse on the iterative path.
    localparam int MD_LAT = 34;

    // rd write-back mux code selecting the sequencer result.
    localparam logic [2:0] RD_MD = 3'd4;

endpackage

// File: rtl/muldiv_dp.sv
// Multiply/divide datapath: 64-bit accumulator, operand register, the
// radix-2 add/subtract step and the final sign correction.
module muldiv_dp
    import muldiv_seq_pkg::*;
(
    input  logic        clk,
    input  logic        load,
    input  logic        step,
    input  logic [2:0]  func3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic [31:0] fix_result
);

    logic [63:0] acc;
    logic [31:0] opnd;
    logic [2:0]  op;
    logic        neg;

    logic        a_neg, b_neg, neg_next;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [32:0] rem_sh;
    logic [31:0] div_diff;
    logic [63:0] prod;
    logic [31:0] part;

    // Operand magnitudes and result sign, decoded from func3 at load time.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        a_neg    = 1'b0;
        b_neg    = 1'b0;
        neg_next = 1'b0;
        if (func3[2]) begin
            a_neg    = !func3[0] && rs1[31];
            b_neg    = !func3[0] && rs2[31];
            neg_next = func3[1] ? a_neg : (a_neg ^ b_neg);
        end else begin
            a_neg    = (func3[1:0] != 2'b11) && rs1[31];
            b_neg    = !func3[1] && rs2[31];
            neg_next = a_neg ^ b_neg;
        end
        a_mag = a_neg ? (~rs1 + 32'd1) : rs1;
        b_mag = b_neg ? (~rs2 + 32'd1) : rs2;
    end

    // One radix-2 iteration: shift-add for multiply, shift-subtract for divide.
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + {1'b0, opnd};
        rem_sh   = acc[63:31];
        div_diff = rem_sh[31:0] - opnd;
    end

    // Accumulator and operand registers.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers carry no reset; they are always loaded before use.
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (load) begin
            op   <= func3;
            neg  <= neg_next;
            opnd <= func3[2] ? b_mag : a_mag;
            acc  <= {32'd0, func3[2] ? a_mag : b_mag};
        end else if (step) begin
            if (op[2]) begin
                if (rem_sh >= {1'b0, opnd})
                    acc <= {div_diff, acc[30:0], 1'b1};
                else
                    acc <= {rem_sh[31:0], acc[30:0], 1'b0};
            end else begin
                if (acc[0])
                    acc <= {mul_sum, acc[31:1]};
                else
                    acc <= {1'b0, acc[63:1]};
            end
        end
    end

    // Sign correction and selection of the part written back.
    always_comb begin
        prod       = neg ? (~acc + 64'd1) : acc;
        part       = op[1] ? acc[63:32] : acc[31:0];
        fix_result = 32'd0;
        if (op[2])
            fix_result = neg ? (~part + 32'd1) : part;
        else if (op == FUNC3_MUL)
            fix_result = prod[31:0];
        else
            fix_result = prod[63:32];
    end

endmodule

// File: rtl/muldiv_seq.sv
// RV32M iterative multiply/divide sequencer: FSM, iteration counter,
// fast paths for divide-by-zero and signed overflow, and the result register.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    logic [1:0]      state, state_next;
    logic [4:0]      count;
    logic            accept;
    logic            fast;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] fast_val;
    logic [XLEN-1:0] fix_result;

    muldiv_dp u_dp (
        .clk        (clk),
        .load       (accept),
        .step       (state == MD_CALC),
        .func3      (func3),
        .rs1        (rs1),
        .rs2        (rs2),
        .fix_result (fix_result)
    );

    // Start acceptance and the two special cases that bypass the loop.
    always_comb begin
        accept   = (state == MD_IDLE) && start && !kill;
        div_zero = func3[2] && (rs2 == '0);
        div_ovf  = func3[2] && !func3[0] && (rs1 == 32'h8000_0000) && (rs2 == '1);
        fast     = div_zero || div_ovf;
        if (func3[1])
            fast_val = div_zero ? rs1 : '0;
        else
            fast_val = div_zero ? '1 : 32'h8000_0000;
        stall = accept || (state == MD_CALC) || (state == MD_FIX);
    end

    // Next-state logic; kill forces IDLE from any state.
    always_comb begin
        state_next = state;
        case (state)
            MD_IDLE: if (accept) state_next = fast ? MD_DONE : MD_CALC;
            MD_CALC: if (count == 5'd0) state_next = MD_FIX;
            MD_FIX:  state_next = MD_DONE;
            default: state_next = MD_IDLE;
        endcase
        if (kill)
            state_next = MD_IDLE;
    end

    // FSM, counter, handshake flags and result register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= MD_IDLE;
            count  <= 5'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next != MD_IDLE);
            done  <= !kill && ((accept && fast) || (state == MD_FIX));
            if (accept)
                count <= 5'd31;
            else if ((state == MD_CALC) && (count != 5'd0))
                count <= count - 5'd1;
            if (accept && fast)
                result <= fast_val;
            else if ((state == MD_FIX) && !kill)
                result <= fix_result;
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: every RV32M operation,
// fast paths, stall/busy timing, kill, ignored start and mid-op reset.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic        kill;
    logic [2:0]  func3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int tests;
    int fails;

    muldiv_seq #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .kill   (kill),
        .func3  (func3),
        .rs1    (rs1),
        .rs2    (rs2),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one operation at the current negedge (cycle 0) and follow it to done.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        int st;
        lat   = -1;
        func3 = f;
        rs1   = a;
        rs2   = b;
        start = 1'b1;
        #1;
        st = stall ? 1 : 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (done) begin
                lat = c;
                break;
            end
            if (stall) st++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " result"}, result, exp_res);
        check({tag, " stall cycles"}, st, exp_lat);
        @(negedge clk);
        #1;
        check({tag, " busy after"}, busy, 1'b0);
        check({tag, " done one-shot"}, done, 1'b0);
    endtask

    initial begin
        int  lat;
        bit  done_seen;
        tests = 0;
        fails = 0;
        rst   = 1'b0;
        start = 1'b0;
        kill  = 1'b0;
        func3 = 3'd0;
        rs1   = 32'd0;
        rs2   = 32'd0;

        repeat (2) @(negedge clk);
        #1;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset result", result, 32'd0);
        check("reset stall", stall, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        run_op("MUL",    FUNC3_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        run_op("MULH",   FUNC3_MULH,   32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 34);
        run_op("MULHU",  FUNC3_MULHU,  32'd7,         32'hFFFF_FFFD, 32'h0000_0006, 34);
        run_op("DIV",    FUNC3_DIV,    32'hFFFF_FFEC, 32'd6,         32'hFFFF_FFFD, 34);
        run_op("REM",    FUNC3_REM,    32'hFFFF_FFEC, 32'd6,         32'hFFFF_FFFE, 34);
        run_op("DIVU",   FUNC3_DIVU,   32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, 34);
        run_op("DIVU0",  FUNC3_DIVU,   32'd123,       32'd0,         32'hFFFF_FFFF, 1);
        run_op("REM0",   FUNC3_REM,    32'd123,       32'd0,         32'd123,       1);
        run_op("DIVOVF", FUNC3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("REMOVF", FUNC3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
        run_op("MULHSU", FUNC3_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
        run_op("MUL2",   FUNC3_MUL,    32'd12345,     32'd1000,      32'd12345000,  34);

        // kill in cycle 10 of a DIV: back to IDLE, no done, result kept.
        func3 = FUNC3_DIV;
        rs1   = 32'hFFFF_FFEC;
        rs2   = 32'd6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        #1;
        check("kill busy", busy, 1'b0);
        check("kill stall", stall, 1'b0);
        done_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        check("kill no done", done_seen, 1'b0);
        check("kill result kept", result, 32'd12345000);

        // start in cycle 5 of a MUL is ignored.
        func3 = FUNC3_MUL;
        rs1   = 32'd7;
        rs2   = 32'hFFFF_FFFD;
        start = 1'b1;
        lat   = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 5) begin
                start = 1'b1;
                func3 = FUNC3_DIVU;
                rs1   = 32'd123;
                rs2   = 32'd0;
            end
            #1;
            if (done) begin
                lat = c;
                break;
            end
        end
        start = 1'b0;
        check("ignored start latency", lat, 34);
        check("ignored start result", result, 32'hFFFF_FFEB);
        @(negedge clk);

        // reset in cycle 20 of a MUL.
        func3 = FUNC3_MUL;
        rs1   = 32'd9;
        rs2   = 32'd9;
        start = 1'b1;
        done_seen = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 20) rst = 1'b0;
            if (c == 21) begin
                rst = 1'b1;
                #1;
                check("midreset busy", busy, 1'b0);
                check("midreset result", result, 32'd0);
            end
            #1;
            if (done) done_seen = 1'b1;
        end
        check("midreset no done", done_seen, 1'b0);

        run_op("DIV after reset", FUNC3_DIV, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFD, 34);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative sequencer for the RV32M multiply/divide instructions. It accepts operands from the register file when the control unit decodes an `OP` instruction with `func7 = 0000001`. It runs a radix-2 shift-add or shift-subtract loop, one bit per cycle. While the loop runs it stalls the fetch/PC path, then presents a registered result for write-back through the `rd` mux. It sits beside the ALU and is sequenced by the core control unit through a start/stall/done handshake.

## Interface
- `XLEN`, default 32: operand/result width. Only 32 is supported.
- `clk`  in  1: clock. All state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-low (0 = reset).
- `start`  in  1: request. Sampled only in IDLE.
- `kill`  in  1: abort current operation. Wins over `start`.
- `func3`  in  3: operation select, sampled with `start`. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1`  in  XLEN: dividend / multiplicand, sampled with `start`.
- `rs2`  in  XLEN: divisor / multiplier, sampled with `start`.
- `stall`  out  1: hold PC and instruction register.
- `busy`  out  1: FSM not in IDLE.
- `done`  out  1: one-cycle pulse; `result` valid this cycle.
- `result`  out  XLEN: registered result. Held until the next accepted `start`.

## Operation
- **States**
  - IDLE, CALC, FIX, DONE.
  - All state is cleared on reset: state = IDLE, count = 0, `result` = 0, `done` = 0, `busy` = 0.
- **IDLE**
  - `start` = 1 and `kill` = 0 latches `func3`.
  - Operands are converted to magnitudes per signedness:
    - MUL/MULH: both signed.
    - MULHSU: `rs1` signed, `rs2` unsigned.
    - DIV/REM: both signed.
    - U forms: both unsigned.
  - The result sign is latched. Count loads 31. Next state is CALC.
- **Fast path:** IDLE goes straight to DONE, skipping CALC and FIX, in two cases.
  - Divide by zero (`rs2` = 0, func3[2] = 1):
    - DIV/DIVU return 0xFFFF_FFFF.
    - REM/REMU return `rs1`.
  - Signed overflow (DIV/REM with `rs1` = 0x8000_0000 and `rs2` = 0xFFFF_FFFF):
    - DIV returns 0x8000_0000.
    - REM returns 0.
- **CALC:** one iteration per cycle on a 64-bit accumulator. When count = 0, next state is FIX; otherwise count decrements.
  - Multiply: if the LSB of the multiplier is set, add the multiplicand into the upper half, then shift the accumulator right by 1.
  - Divide: shift the remainder:quotient pair left by 1. Trial-subtract the divisor; if the difference is ≥ 0, keep it and set the quotient LSB.
- **FIX**
  - If the latched sign is negative, take the two's complement of the selected part.
    - Multiply: the full 64-bit product.
    - DIV: the quotient.
    - REM: the remainder, which takes the sign of the dividend.
  - Selected part:
    - MUL: low 32 bits.
    - MULH, MULHSU, MULHU: high 32 bits.
    - DIV, DIVU: quotient.
    - REM, REMU: remainder.
  - The selected part is written into `result`. Next state is DONE.
- **DONE:** `done` = 1 for exactly one cycle, then IDLE. A `start` during DONE is ignored; the controller re-issues it after seeing `done`.
- **kill:** any state goes to IDLE next edge.
  - `done` is not asserted and `result` is unchanged.
  - kill during DONE suppresses nothing: `done` was already this cycle's output.
- `start` while `busy` = 1 is ignored.

## Timing
- `start` is accepted in cycle 0.
  - CALC occupies cycles 1–32, FIX cycle 33, DONE cycle 34.
  - Normal latency is 34 cycles from the start cycle to `done`.
- Fast-path latency is 1 cycle: `done` in cycle 1.
- `stall` is combinational: `(state == IDLE && start && !kill) || state == CALC || state == FIX`.
  - It is high in cycle 0 through cycle 33 and low in the DONE cycle.
  - This lets the control unit write `result` back and advance PC in the DONE cycle.
- `busy` = state ≠ IDLE, registered.
- Reset mid-operation: IDLE, `result` = 0, no `done` on the following edge.
- Latency is independent of operand values; there is no early termination.

## Structure
- `rysy_pkg.vh` gains:
  - `FUNC7_MULDIV` (7'b0000001).
  - `FUNC3_MUL` … `FUNC3_REMU`.
  - State encodings `MD_IDLE`, `MD_CALC`, `MD_FIX`, `MD_DONE`.
  - `MD_LAT` (34).
- Control-unit hookup:
  - `start` decode.
  - OR of `stall` into the PC/instruction hold.
  - A new `rd_sel` code `RD_MD`, added to the package.
- One sub-module is natural: `muldiv_dp`, holding the 64-bit accumulator, operand/divisor registers, adder/subtractor and negation logic, driven by step/load/fix strobes. The FSM and counter stay in `muldiv_seq`.

## Test plan
- MUL with `rs1` = 7, `rs2` = -3 (0xFFFF_FFFD) → `done` in cycle 34, `result` = 0xFFFF_FFEB. MULH on the same operands → 0xFFFF_FFFF; MULHU → 0x0000_0006.
- DIV with `rs1` = -20, `rs2` = 6 → `result` = 0xFFFF_FFFD (-3). REM on the same operands → 0xFFFF_FFFE (-2). DIVU 0xFFFF_FFFF / 2 → 0x7FFF_FFFF.
- DIVU 123 / 0 → `done` in cycle 1, `result` = 0xFFFF_FFFF. REM 123 / 0 → 123. DIV 0x8000_0000 / -1 → 0x8000_0000, `stall` high only in cycle 0.
- MULHSU with `rs1` = 0x8000_0000, `rs2` = 0xFFFF_FFFF → 0x8000_0000. `stall` is high in cycles 0–33, low in cycle 34, and `busy` returns to 0 in cycle 35.
- `kill` in cycle 10 of a DIV → IDLE in cycle 11, no `done`, `result` still holds the prior value. A `start` asserted in cycle 5 of a MUL is ignored.
- `rst` = 0 in cycle 20 of a MUL → `busy` = 0, `result` = 0, `done` never pulses. A new `start` after reset completes normally.
